// File: rtl/z_word_packer_pkg.sv
// Shared types and helpers for the z-bit word packer: output-register state
// encoding, the default word width and a population-count function.
package z_word_packer_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // popcount is sized for the widest legal word; callers zero-extend their
    // word and truncate the result to their own count width.
    localparam int MAX_WIDTH = 32;
    localparam int MAX_CW    = 6;

    function automatic logic [MAX_CW-1:0] popcount(input logic [MAX_WIDTH-1:0] word);
        logic [MAX_CW-1:0] cnt;
        cnt = {MAX_CW{1'b0}};
        for (int i = 0; i < MAX_WIDTH; i++) begin
            cnt = cnt + {{(MAX_CW-1){1'b0}}, word[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/z_word_packer.sv
// Packs strobed detector bits MSB-first into WIDTH-bit words and offers each
// word with its ones count through a one-entry valid/ready output register.
module z_word_packer
    import z_word_packer_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z_in,
    input  logic             z_en,
    output logic [WIDTH-1:0] word_out,
    output logic [CW-1:0]    ones_cnt,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    // The newest bit always comes straight from z_in, so only the previous
    // WIDTH-1 bits of the shift history need storing.
    logic [WIDTH-2:0] sr_r;
    logic [CW-1:0]    bcnt_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] word_r;
    logic [CW-1:0]    ones_r;
    logic             valid_r;
    logic             overrun_r;

    logic [WIDTH-1:0] new_word_s;
    logic [CW-1:0]    new_ones_s;
    logic             complete_s;
    logic             load_s;
    logic             drop_s;

    assign new_word_s = {sr_r, z_in};
    assign new_ones_s = CW'(popcount(MAX_WIDTH'(new_word_s)));
    assign complete_s = z_en && (bcnt_r == LAST_IDX);

    // Collector: shift in strobed bits and count position within the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_r   <= {(WIDTH-1){1'b0}};
            bcnt_r <= {CW{1'b0}};
        end else if (z_en) begin
            sr_r <= new_word_s[WIDTH-2:0];
            if (complete_s) begin
                bcnt_r <= {CW{1'b0}};
            end else begin
                bcnt_r <= bcnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            sr_r   <= sr_r;
            bcnt_r <= bcnt_r;
        end
    end

    // Output register next state, load and drop decisions.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            EMPTY: begin
                if (complete_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (word_ready) begin
                    if (complete_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = FULL;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end else begin
                    drop_s      = complete_s;
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // Output register state, held word and its ones count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= EMPTY;
            valid_r <= 1'b0;
            word_r  <= {WIDTH{1'b0}};
            ones_r  <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s == FULL);
            if (load_s) begin
                word_r <= new_word_s;
                ones_r <= new_ones_s;
            end else begin
                word_r <= word_r;
                ones_r <= ones_r;
            end
        end
    end

    // Sticky overrun flag; a drop outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (clr_overrun) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign word_out   = word_r;
    assign ones_cnt   = ones_r;
    assign word_valid = valid_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_z_word_packer.sv
// Self-checking bench for z_word_packer (WIDTH=8): table of single words,
// hand-written handshake corner cases and a randomized run against a queue model.
module tb_z_word_packer;

    logic       clk = 1'b0;
    logic       reset;
    logic       z_in;
    logic       z_en;
    logic [7:0] word_out;
    logic [3:0] ones_cnt;
    logic       word_valid;
    logic       word_ready;
    logic       overrun;
    logic       clr_overrun;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: collected bits, held word, valid and overrun.
    bit         mq[$];
    logic [7:0] m_word;
    logic       m_valid;
    logic       m_ovr;

    typedef struct {
        logic [7:0] w;
        logic [3:0] ones;
    } vec_t;
    vec_t tbl[8];

    z_word_packer #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .z_in        (z_in),
        .z_en        (z_en),
        .word_out    (word_out),
        .ones_cnt    (ones_cnt),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic en, input logic zi,
                              input logic rdy, input logic clr);
        logic [7:0] w;
        logic comp;
        logic drop;
        w    = 8'h00;
        comp = 1'b0;
        drop = 1'b0;
        if (r) begin
            mq.delete();
            m_word  = 8'h00;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            if (en) begin
                mq.push_back(zi);
                if (mq.size() == 8) begin
                    comp = 1'b1;
                    for (int i = 0; i < 8; i++) w[7-i] = mq[i];
                    mq.delete();
                end
            end
            if (comp) begin
                if (!m_valid || rdy) begin
                    m_word  = w;
                    m_valid = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (drop) m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic en, input logic zi,
                        input logic rdy, input logic clr);
        reset       = r;
        z_en        = en;
        z_in        = zi;
        word_ready  = rdy;
        clr_overrun = clr;
        model_edge(r, en, zi, rdy, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] w, input logic rdy_rest,
                        input logic rdy_last, input logic clr_last);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, w[i], (i == 0) ? rdy_last : rdy_rest,
                 (i == 0) ? clr_last : 1'b0);
        end
    endtask

    task automatic chk_out(input string nm, input logic [7:0] w, input logic [3:0] ones,
                           input logic v, input logic ov);
        chk({nm, ".word"}, 32'(word_out), 32'(w));
        chk({nm, ".ones"}, 32'(ones_cnt), 32'(ones));
        chk({nm, ".valid"}, 32'(word_valid), 32'(v));
        chk({nm, ".ovr"}, 32'(overrun), 32'(ov));
    endtask

    initial begin
        tbl[0] = '{8'hB2, 4'd4};
        tbl[1] = '{8'hFF, 4'd8};
        tbl[2] = '{8'h00, 4'd0};
        tbl[3] = '{8'h01, 4'd1};
        tbl[4] = '{8'h80, 4'd1};
        tbl[5] = '{8'h3C, 4'd4};
        tbl[6] = '{8'hAA, 4'd4};
        tbl[7] = '{8'h7F, 4'd7};

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("reset", 8'h00, 4'd0, 1'b0, 1'b0);

        // Single words: valid for exactly one cycle with ready held high.
        foreach (tbl[k]) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            feed(tbl[k].w, 1'b1, 1'b1, 1'b0);
            chk_out($sformatf("tbl%0d", k), tbl[k].w, tbl[k].ones, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("tbl%0d.fall", k), 32'(word_valid), 32'd0);
        end

        // Continuous strobes: FF then 01.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed(8'hFF, 1'b1, 1'b1, 1'b0);
        chk_out("b2b_ff", 8'hFF, 4'd8, 1'b1, 1'b0);
        feed(8'h01, 1'b1, 1'b1, 1'b0);
        chk_out("b2b_01", 8'h01, 4'd1, 1'b1, 1'b0);

        // Stall: second word dropped, first kept, then delivered.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed(8'h0F, 1'b0, 1'b0, 1'b0);
        chk_out("stall_0f", 8'h0F, 4'd4, 1'b1, 1'b0);
        feed(8'hAA, 1'b0, 1'b0, 1'b0);
        chk_out("drop_aa", 8'h0F, 4'd4, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("deliver_0f", 8'h0F, 4'd4, 1'b0, 1'b1);

        // Overrun clear without a drop, then clear colliding with a drop.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovr", 32'(overrun), 32'd0);
        feed(8'h55, 1'b0, 1'b0, 1'b0);
        chk_out("hold_55", 8'h55, 4'd4, 1'b1, 1'b0);
        feed(8'h33, 1'b0, 1'b0, 1'b1);
        chk_out("set_wins", 8'h55, 4'd4, 1'b1, 1'b1);

        // Ready rises on the same edge a new word completes.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed(8'hC3, 1'b0, 1'b0, 1'b0);
        chk_out("held_c3", 8'hC3, 4'd4, 1'b1, 1'b0);
        feed(8'h5A, 1'b0, 1'b1, 1'b0);
        chk_out("swap_5a", 8'h5A, 4'd4, 1'b1, 1'b0);

        // Reset mid-word discards the partial bits.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed(8'h3C, 1'b1, 1'b1, 1'b0);
        chk_out("partial_3c", 8'h3C, 4'd4, 1'b1, 1'b0);

        // Reset while FULL discards the held word.
        feed(8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("reset_full", 8'h00, 4'd0, 1'b0, 1'b0);

        // Randomized traffic against the queue model.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
            chk("rnd.word", 32'(word_out), 32'(m_word));
            chk("rnd.ones", 32'(ones_cnt), 32'($countones(m_word)));
            chk("rnd.valid", 32'(word_valid), 32'(m_valid));
            chk("rnd.ovr", 32'(overrun), 32'(m_ovr));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
